// File: rtl/io_hs_if.sv
// io_hs_if: signal bundle between the I/O handshake sequencer, the stage-1
// controller and the external byte I/O devices.
//   master : the sequencer (drives device acks, output_bus, status pulses)
//   slave  : its environment (stage-1 requests and device handshakes)
// Stage-1 side : in_req, out_req, out_data, rd_data, mdr_load, busy,
//                done, timeout_err
// Device side  : in_dev_hs, input_bus, in_dev_ack, out_dev_hs, out_dev_ack,
//                output_bus, out_valid
interface io_hs_if #(
  parameter int DW = 8
);
  logic          in_req;
  logic          out_req;
  logic [DW-1:0] out_data;
  logic          in_dev_hs;
  logic [DW-1:0] input_bus;
  logic          in_dev_ack;
  logic          out_dev_hs;
  logic          out_dev_ack;
  logic [DW-1:0] output_bus;
  logic          out_valid;
  logic [DW-1:0] rd_data;
  logic          mdr_load;
  logic          busy;
  logic          done;
  logic          timeout_err;

  modport master (
    input  in_req, out_req, out_data, in_dev_hs, input_bus,
           out_dev_hs, out_dev_ack,
    output in_dev_ack, output_bus, out_valid, rd_data, mdr_load,
           busy, done, timeout_err
  );

  modport slave (
    output in_req, out_req, out_data, in_dev_hs, input_bus,
           out_dev_hs, out_dev_ack,
    input  in_dev_ack, output_bus, out_valid, rd_data, mdr_load,
           busy, done, timeout_err
  );
endinterface

// File: rtl/io_hs_ctrl.sv
// io_hs_ctrl: sequencer for the processor's external byte I/O ports.
// Runs a four-phase handshake with the input device (IN) or the output
// device (OUT) on behalf of stage-1, and reports done / timeout_err.
// Ports:
//   g_clk : rising-edge clock
//   g_clr : synchronous active-high reset
//   bus   : io_hs_if master modport (requests, device handshakes, status)
// All outputs are registered. Each wait state is bounded by TIMEOUT cycles
// (TIMEOUT = 0 disables the bound).
module io_hs_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic     g_clk,
  input  logic     g_clr,
  io_hs_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    IN_WAIT      = 3'd1,
    IN_ACK       = 3'd2,
    OUT_WAIT_RDY = 3'd3,
    OUT_DRIVE    = 3'd4,
    OUT_RELEASE  = 3'd5
  } state_t;

  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};

  state_t        state_r, state_nxt_s;
  logic [TW-1:0] timer_r, timer_nxt_s;
  logic          in_dev_ack_r, in_dev_ack_nxt_s;
  logic          out_valid_r, out_valid_nxt_s;
  logic [DW-1:0] output_bus_r, output_bus_nxt_s;
  logic [DW-1:0] rd_data_r, rd_data_nxt_s;
  logic          mdr_load_r, mdr_load_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          done_r, done_nxt_s;
  logic          timeout_err_r, timeout_err_nxt_s;
  logic          timer_hit_s;

  // Timer has reached the bound; only meaningful when the bound is enabled.
  assign timer_hit_s = (TIMEOUT_C != {TW{1'b0}}) && (timer_r == TIMEOUT_C);

  // Next-state and next-output decode; pulses default low, levels hold.
  always_comb begin
    state_nxt_s       = state_r;
    in_dev_ack_nxt_s  = in_dev_ack_r;
    out_valid_nxt_s   = out_valid_r;
    output_bus_nxt_s  = output_bus_r;
    rd_data_nxt_s     = rd_data_r;
    mdr_load_nxt_s    = 1'b0;
    done_nxt_s        = 1'b0;
    timeout_err_nxt_s = 1'b0;

    case (state_r)
      IDLE: begin
        // IN has priority; a simultaneous out_req is dropped.
        if (bus.in_req) begin
          state_nxt_s = IN_WAIT;
        end else if (bus.out_req) begin
          state_nxt_s      = OUT_WAIT_RDY;
          output_bus_nxt_s = bus.out_data;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IN_WAIT: begin
        if (bus.in_dev_hs) begin
          state_nxt_s      = IN_ACK;
          rd_data_nxt_s    = bus.input_bus;
          mdr_load_nxt_s   = 1'b1;
          in_dev_ack_nxt_s = 1'b1;
        end else if (timer_hit_s) begin
          state_nxt_s       = IDLE;
          timeout_err_nxt_s = 1'b1;
          in_dev_ack_nxt_s  = 1'b0;
          out_valid_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IN_WAIT;
        end
      end
      IN_ACK: begin
        if (!bus.in_dev_hs) begin
          state_nxt_s      = IDLE;
          in_dev_ack_nxt_s = 1'b0;
          done_nxt_s       = 1'b1;
        end else if (timer_hit_s) begin
          state_nxt_s       = IDLE;
          timeout_err_nxt_s = 1'b1;
          in_dev_ack_nxt_s  = 1'b0;
          out_valid_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IN_ACK;
        end
      end
      OUT_WAIT_RDY: begin
        if (bus.out_dev_hs) begin
          state_nxt_s     = OUT_DRIVE;
          out_valid_nxt_s = 1'b1;
        end else if (timer_hit_s) begin
          state_nxt_s       = IDLE;
          timeout_err_nxt_s = 1'b1;
          in_dev_ack_nxt_s  = 1'b0;
          out_valid_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = OUT_WAIT_RDY;
        end
      end
      OUT_DRIVE: begin
        if (bus.out_dev_ack) begin
          state_nxt_s     = OUT_RELEASE;
          out_valid_nxt_s = 1'b0;
        end else if (timer_hit_s) begin
          state_nxt_s       = IDLE;
          timeout_err_nxt_s = 1'b1;
          in_dev_ack_nxt_s  = 1'b0;
          out_valid_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = OUT_DRIVE;
        end
      end
      OUT_RELEASE: begin
        if (!bus.out_dev_ack) begin
          state_nxt_s = IDLE;
          done_nxt_s  = 1'b1;
        end else if (timer_hit_s) begin
          state_nxt_s       = IDLE;
          timeout_err_nxt_s = 1'b1;
          in_dev_ack_nxt_s  = 1'b0;
          out_valid_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = OUT_RELEASE;
        end
      end
      default: begin
        state_nxt_s      = IDLE;
        in_dev_ack_nxt_s = 1'b0;
        out_valid_nxt_s  = 1'b0;
      end
    endcase

    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // Wait timer: cleared on any state change, saturating count while waiting.
  always_comb begin
    if (state_nxt_s != state_r) begin
      timer_nxt_s = {TW{1'b0}};
    end else if ((state_r != IDLE) && (timer_r != TIMER_MAX)) begin
      timer_nxt_s = timer_r + TW'(1'b1);
    end else begin
      timer_nxt_s = timer_r;
    end
  end

  // State, timer and output registers with synchronous clear.
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_r       <= IDLE;
      timer_r       <= {TW{1'b0}};
      in_dev_ack_r  <= 1'b0;
      out_valid_r   <= 1'b0;
      output_bus_r  <= {DW{1'b0}};
      rd_data_r     <= {DW{1'b0}};
      mdr_load_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      timer_r       <= timer_nxt_s;
      in_dev_ack_r  <= in_dev_ack_nxt_s;
      out_valid_r   <= out_valid_nxt_s;
      output_bus_r  <= output_bus_nxt_s;
      rd_data_r     <= rd_data_nxt_s;
      mdr_load_r    <= mdr_load_nxt_s;
      busy_r        <= busy_nxt_s;
      done_r        <= done_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  assign bus.in_dev_ack  = in_dev_ack_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.output_bus  = output_bus_r;
  assign bus.rd_data     = rd_data_r;
  assign bus.mdr_load    = mdr_load_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_io_hs_ctrl.sv
// tb_io_hs_ctrl: directed self-checking bench for io_hs_ctrl (TIMEOUT = 4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_io_hs_ctrl;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;

  io_hs_if #(.DW(8)) bus ();

  io_hs_ctrl #(.DW(8), .TIMEOUT(4), .TW(8)) dut (
    .g_clk (clk),
    .g_clr (clr),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all status pulses/levels in one go.
  task automatic check_status(input string tag, input logic busy_e,
                              input logic done_e, input logic to_e,
                              input logic mdr_e);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'(busy_e));
    check_eq({tag, "_done"}, 32'(bus.done), 32'(done_e));
    check_eq({tag, "_tmo"},  32'(bus.timeout_err), 32'(to_e));
    check_eq({tag, "_mdr"},  32'(bus.mdr_load), 32'(mdr_e));
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    clr             = 1'b1;
    bus.in_req      = 1'b0;
    bus.out_req     = 1'b0;
    bus.out_data    = 8'h00;
    bus.in_dev_hs   = 1'b0;
    bus.input_bus   = 8'h00;
    bus.out_dev_hs  = 1'b0;
    bus.out_dev_ack = 1'b0;

    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      bus.in_req      = 1'($urandom);
      bus.out_req     = 1'($urandom);
      bus.out_data    = 8'($urandom);
      bus.in_dev_hs   = 1'($urandom);
      bus.input_bus   = 8'($urandom);
      bus.out_dev_hs  = 1'($urandom);
      bus.out_dev_ack = 1'($urandom);
      tick();
      check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_ack", 32'(bus.in_dev_ack), 32'd0);
      check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_obus", 32'(bus.output_bus), 32'h00);
      check_eq("rst_rd", 32'(bus.rd_data), 32'h00);
    end
    clr             = 1'b0;
    bus.in_req      = 1'b0;
    bus.out_req     = 1'b0;
    bus.in_dev_hs   = 1'b0;
    bus.out_dev_hs  = 1'b0;
    bus.out_dev_ack = 1'b0;
    tick();
    check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // IN transfer of 8'hA5.
    bus.input_bus = 8'hA5;
    bus.in_req    = 1'b1;
    tick();
    check_status("in_acc", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("in_acc_ack", 32'(bus.in_dev_ack), 32'd0);
    bus.in_req = 1'b0;
    tick();
    check_status("in_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.in_dev_hs = 1'b1;
    tick();
    check_status("in_cap", 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("in_cap_rd", 32'(bus.rd_data), 32'hA5);
    check_eq("in_cap_ack", 32'(bus.in_dev_ack), 32'd1);
    tick();
    check_status("in_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("in_hold_ack", 32'(bus.in_dev_ack), 32'd1);
    bus.in_dev_hs = 1'b0;
    tick();
    check_status("in_done", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("in_done_ack", 32'(bus.in_dev_ack), 32'd0);
    check_eq("in_done_rd", 32'(bus.rd_data), 32'hA5);
    tick();
    check_status("in_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // OUT transfer of 8'h3C, device ready after 3 cycles.
    bus.out_data = 8'h3C;
    bus.out_req  = 1'b1;
    tick();
    check_status("out_acc", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("out_acc_obus", 32'(bus.output_bus), 32'h3C);
    bus.out_req  = 1'b0;
    bus.out_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("out_wait_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.out_dev_hs = 1'b1;
    tick();
    check_eq("out_drv_valid", 32'(bus.out_valid), 32'd1);
    check_eq("out_drv_obus", 32'(bus.output_bus), 32'h3C);
    bus.out_dev_hs  = 1'b0;
    bus.out_dev_ack = 1'b1;
    tick();
    check_eq("out_rel_valid", 32'(bus.out_valid), 32'd0);
    check_status("out_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.out_dev_ack = 1'b0;
    tick();
    check_status("out_done", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("out_done_obus", 32'(bus.output_bus), 32'h3C);
    tick();
    check_status("out_after", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("out_keep_obus", 32'(bus.output_bus), 32'h3C);

    // Simultaneous requests: IN wins, out_req dropped.
    bus.input_bus = 8'h5A;
    bus.out_data  = 8'h55;
    bus.in_req    = 1'b1;
    bus.out_req   = 1'b1;
    tick();
    check_eq("both_obus", 32'(bus.output_bus), 32'h3C);
    bus.in_req    = 1'b0;
    bus.out_req   = 1'b0;
    bus.in_dev_hs = 1'b1;
    tick();
    check_status("both_cap", 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("both_rd", 32'(bus.rd_data), 32'h5A);
    check_eq("both_valid", 32'(bus.out_valid), 32'd0);
    bus.in_dev_hs = 1'b0;
    tick();
    check_status("both_done", 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("both_obus2", 32'(bus.output_bus), 32'h3C);

    // Timeout in IN_WAIT: abort on the 5th edge after acceptance.
    bus.in_req = 1'b1;
    tick();
    bus.in_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_status("tmo_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_status("tmo_hit", 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("tmo_ack", 32'(bus.in_dev_ack), 32'd0);
    tick();
    check_status("tmo_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of OUT_DRIVE.
    bus.out_data = 8'hC3;
    bus.out_req  = 1'b1;
    tick();
    bus.out_req    = 1'b0;
    bus.out_dev_hs = 1'b1;
    tick();
    check_eq("mid_valid", 32'(bus.out_valid), 32'd1);
    bus.out_dev_hs = 1'b0;
    clr            = 1'b1;
    tick();
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    tick();
    check_status("mid_post", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh OUT after the reset completes normally.
    bus.out_data = 8'h81;
    bus.out_req  = 1'b1;
    tick();
    bus.out_req    = 1'b0;
    bus.out_dev_hs = 1'b1;
    tick();
    check_eq("new_valid", 32'(bus.out_valid), 32'd1);
    check_eq("new_obus", 32'(bus.output_bus), 32'h81);
    bus.out_dev_hs  = 1'b0;
    bus.out_dev_ack = 1'b1;
    tick();
    check_eq("new_rel_valid", 32'(bus.out_valid), 32'd0);
    bus.out_dev_ack = 1'b0;
    tick();
    check_status("new_done", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
